hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Pipeline hazard sequencer for the 5-stage MIPS core. Sits beside forwarding_unit and covers the hazards forwarding cannot resolve.
- Detects load-use hazards in ID and inserts one bubble.
- Flushes IF/ID and ID/EX on a taken branch resolved in EX.
- Holds a multi-cycle MULT/DIV in EX with an FSM and counter. Keeps a saturating stall-cycle counter for performance measurement.

Parameters:
LAT_MULTDIV, 4, total cycles a MULT/DIV occupies EX; legal range 2..16
CNT_W, 16, width of the stall-cycle counter

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
IF_ID_rs  input  5  rs field of the instruction in ID
IF_ID_rt  input  5  rt field of the instruction in ID
ID_EX_rt  input  5  destination register of the instruction in EX (load target)
ID_EX_LeMem  input  1  instruction in EX is a load
ID_EX_MultDiv  input  1  instruction in EX is a MULT/DIV
EX_desvio_tomado  input  1  branch in EX is taken
PC_escreve  output  1  PC write enable
IF_ID_escreve  output  1  IF/ID register write enable
ID_EX_escreve  output  1  ID/EX register write enable
IF_ID_flush  output  1  clear IF/ID to NOP
ID_EX_flush  output  1  load NOP (bubble) into ID/EX
EX_MEM_bolha  output  1  load NOP into EX/MEM
md_pronto  output  1  MULT/DIV result valid this cycle
cont_bolhas  output  CNT_W  saturating count of cycles with PC_escreve=0

Behaviour:
Reset (reset=0, asynchronous, effective at any time including mid MULT/DIV):
- State returns to OCIOSO; cnt=0; cont_bolhas=0.
- While reset is low, all combinational outputs are forced to: PC_escreve=1, IF_ID_escreve=1, ID_EX_escreve=1, IF_ID_flush=0, ID_EX_flush=0, EX_MEM_bolha=0, md_pronto=0.

Default outputs (no hazard): enables = 1, flushes/bolha = 0, md_pronto = 0.

FSM and counter:
- States: OCIOSO and OCUPADO. Counter cnt is 4 bits.
- All outputs are combinational from state, cnt and inputs, so they take effect in the same cycle.

OCIOSO, evaluated in priority order:
1. EX_desvio_tomado=1:
   - IF_ID_flush=1, ID_EX_flush=1, PC_escreve=1.
   - MultDiv and load-use inputs are ignored; state stays OCIOSO.
2. ID_EX_MultDiv=1:
   - Stall: PC_escreve=0, IF_ID_escreve=0, ID_EX_escreve=0, EX_MEM_bolha=1.
   - Next state: cnt<=LAT_MULTDIV-2, go to OCUPADO.
3. Load-use: ID_EX_LeMem=1, ID_EX_rt!=0, and (ID_EX_rt==IF_ID_rs or ID_EX_rt==IF_ID_rt):
   - PC_escreve=0, IF_ID_escreve=0, ID_EX_flush=1. This is exactly one bubble.
   - The following cycle re-evaluates with the load in MEM, where forwarding covers it.

OCUPADO:
- cnt!=0:
  - Same stall pattern as OCIOSO item 2; cnt<=cnt-1.
  - EX_desvio_tomado and load-use are ignored, since EX holds the MULT/DIV.
- cnt==0:
  - md_pronto=1, no stall; the instruction advances.
  - Next state OCIOSO. Hazard checks are not evaluated this cycle.

Timing:
- A MULT/DIV occupies EX for exactly LAT_MULTDIV cycles.
- The first LAT_MULTDIV-1 of those cycles are stalls; md_pronto is high only in the last one.
- Back-to-back MULT/DIV: the second instruction enters EX the cycle after md_pronto and restarts the sequence from OCIOSO.

cont_bolhas:
- Increments on each rising edge where PC_escreve=0.
- Saturates at 2^CNT_W-1; never wraps.
- Branch flush cycles do not count.

Test Plan:
- Reset pulse mid-OCUPADO (cnt=1) -> outputs immediately return to defaults, cont_bolhas=0; next ID_EX_MultDiv=1 restarts the full 4-cycle sequence.
- ID_EX_LeMem=1, ID_EX_rt=5, IF_ID_rs=5 -> one cycle of PC_escreve=0, IF_ID_escreve=0, ID_EX_flush=1. Same stimulus with ID_EX_rt=0 -> no stall.
- ID_EX_MultDiv=1 held, LAT_MULTDIV=4 -> 3 cycles of stall with EX_MEM_bolha=1, 4th cycle md_pronto=1 and enables=1; cont_bolhas +3.
- EX_desvio_tomado=1 together with load-use match -> IF_ID_flush=1, ID_EX_flush=1, PC_escreve=1, no stall, cont_bolhas unchanged.
- EX_desvio_tomado=1 during OCUPADO -> ignored; stall sequence unaffected.
- CNT_W=4, hold a load-use hazard for 20 cycles -> cont_bolhas saturates at 15 and stays there.

Source files
------------

// File: rtl/hazard_controller.sv
// hazard_controller: stall/flush sequencer for the 5-stage MIPS core.
// Resolves load-use hazards with one bubble, flushes on taken branches
// resolved in EX, holds EX for multi-cycle MULT/DIV, and counts stall cycles.
module hazard_controller #(
    parameter int LAT_MULTDIV = 4,   // total cycles a MULT/DIV occupies EX (2..16)
    parameter int CNT_W       = 16   // stall-cycle counter width
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       IF_ID_rs,
    input  logic [4:0]       IF_ID_rt,
    input  logic [4:0]       ID_EX_rt,
    input  logic             ID_EX_LeMem,
    input  logic             ID_EX_MultDiv,
    input  logic             EX_desvio_tomado,
    output logic             PC_escreve,
    output logic             IF_ID_escreve,
    output logic             ID_EX_escreve,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             EX_MEM_bolha,
    output logic             md_pronto,
    output logic [CNT_W-1:0] cont_bolhas
);

    typedef enum logic {OCIOSO = 1'b0, OCUPADO = 1'b1} state_e;

    // Remaining stall cycles after the first one spent in OCIOSO; the last
    // EX cycle (cnt==0) is the release cycle with md_pronto.
    localparam logic [3:0] CNT_INIT = 4'(LAT_MULTDIV - 2);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] cont_q, cont_d;
    logic             load_use;

    // Load in EX writes a register that the instruction in ID reads ($0 never hazards).
    assign load_use = ID_EX_LeMem && (ID_EX_rt != 5'd0) &&
                      ((ID_EX_rt == IF_ID_rs) || (ID_EX_rt == IF_ID_rt));

    // State, MULT/DIV counter and stall counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= OCIOSO;
            cnt_q   <= 4'd0;
            cont_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cont_q  <= cont_d;
        end
    end

    // Next state: a taken branch in OCIOSO pre-empts a MULT/DIV entering EX.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            OCIOSO: begin
                if (!EX_desvio_tomado && ID_EX_MultDiv) begin
                    state_d = OCUPADO;
                    cnt_d   = CNT_INIT;
                end
            end
            OCUPADO: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                else               state_d = OCIOSO;
            end
            default: state_d = OCIOSO;
        endcase
    end

    // Outputs: purely combinational so stalls/flushes act in the same cycle.
    always_comb begin
        PC_escreve    = 1'b1;
        IF_ID_escreve = 1'b1;
        ID_EX_escreve = 1'b1;
        IF_ID_flush   = 1'b0;
        ID_EX_flush   = 1'b0;
        EX_MEM_bolha  = 1'b0;
        md_pronto     = 1'b0;
        if (reset) begin
            unique case (state_q)
                OCIOSO: begin
                    if (EX_desvio_tomado) begin
                        IF_ID_flush = 1'b1;
                        ID_EX_flush = 1'b1;
                    end else if (ID_EX_MultDiv) begin
                        PC_escreve    = 1'b0;
                        IF_ID_escreve = 1'b0;
                        ID_EX_escreve = 1'b0;
                        EX_MEM_bolha  = 1'b1;
                    end else if (load_use) begin
                        PC_escreve    = 1'b0;
                        IF_ID_escreve = 1'b0;
                        ID_EX_flush   = 1'b1;
                    end
                end
                OCUPADO: begin
                    // EX holds the MULT/DIV, so branch and load-use inputs are ignored.
                    if (cnt_q != 4'd0) begin
                        PC_escreve    = 1'b0;
                        IF_ID_escreve = 1'b0;
                        ID_EX_escreve = 1'b0;
                        EX_MEM_bolha  = 1'b1;
                    end else begin
                        md_pronto = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_comb begin
        cont_d = cont_q;
        if (!PC_escreve && (cont_q != CNT_MAX)) cont_d = cont_q + CNT_W'(1);
    end

    assign cont_bolhas = cont_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: expected outputs are queued as each
// cycle's stimulus is driven and popped when outputs are sampled mid-cycle.
module tb_hazard_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] IF_ID_rs, IF_ID_rt, ID_EX_rt;
    logic       le, md, br;

    logic        pc_w, ifid_w, idex_w, ifid_f, idex_f, bolha, pronto;
    logic [15:0] cont;
    logic        pc_w2, ifid_w2, idex_w2, ifid_f2, idex_f2, bolha2, pronto2;
    logic [3:0]  cont2;
    logic [6:0]  outv;

    assign outv = {pc_w, ifid_w, idex_w, ifid_f, idex_f, bolha, pronto};

    // {PC_escreve, IF_ID_escreve, ID_EX_escreve, IF_ID_flush, ID_EX_flush, EX_MEM_bolha, md_pronto}
    localparam logic [6:0] DEF = 7'b1110000;
    localparam logic [6:0] LU  = 7'b0010100;
    localparam logic [6:0] MD  = 7'b0000010;
    localparam logic [6:0] RDY = 7'b1110001;
    localparam logic [6:0] BR  = 7'b1111100;

    typedef struct packed {
        logic [6:0]  o;
        logic [15:0] c;
        logic [3:0]  c2;
    } exp_t;

    exp_t sb[$];
    int   exp_cont  = 0;
    int   exp_cont2 = 0;
    int   n_chk     = 0;
    int   n_fail    = 0;

    hazard_controller #(.LAT_MULTDIV(4), .CNT_W(16)) dut (
        .clock(clock), .reset(reset),
        .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .ID_EX_rt(ID_EX_rt),
        .ID_EX_LeMem(le), .ID_EX_MultDiv(md), .EX_desvio_tomado(br),
        .PC_escreve(pc_w), .IF_ID_escreve(ifid_w), .ID_EX_escreve(idex_w),
        .IF_ID_flush(ifid_f), .ID_EX_flush(idex_f), .EX_MEM_bolha(bolha),
        .md_pronto(pronto), .cont_bolhas(cont)
    );

    hazard_controller #(.LAT_MULTDIV(4), .CNT_W(4)) dut_sat (
        .clock(clock), .reset(reset),
        .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .ID_EX_rt(ID_EX_rt),
        .ID_EX_LeMem(le), .ID_EX_MultDiv(md), .EX_desvio_tomado(br),
        .PC_escreve(pc_w2), .IF_ID_escreve(ifid_w2), .ID_EX_escreve(idex_w2),
        .IF_ID_flush(ifid_f2), .ID_EX_flush(idex_f2), .EX_MEM_bolha(bolha2),
        .md_pronto(pronto2), .cont_bolhas(cont2)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Queue the expectation for the current cycle; the counters advance on
    // the coming edge whenever this cycle stalls the PC.
    task automatic push_exp(input logic [6:0] o);
        exp_t e;
        e.o  = o;
        e.c  = 16'(exp_cont);
        e.c2 = 4'(exp_cont2);
        sb.push_back(e);
        if (!o[6]) begin
            if (exp_cont < 65535) exp_cont++;
            if (exp_cont2 < 15)   exp_cont2++;
        end
    endtask

    task automatic drive(input logic [17:0] s);
        {IF_ID_rs, IF_ID_rt, ID_EX_rt, le, md, br} = s;
    endtask

    task automatic test_reset;
        exp_t e;
        drive({5'd5, 5'd0, 5'd5, 3'b110});
        reset = 1'b1;
        #1 reset = 1'b0;
        exp_cont = 0; exp_cont2 = 0;
        @(negedge clock);
        @(negedge clock);
        push_exp(DEF);
        #2 e = sb.pop_front();
        n_chk++;
        if (outv !== e.o || cont !== e.c) begin
            n_fail++;
            $display("FAIL reset_state: outs=%b cont=%0d, want outs=%b cont=%0d", outv, cont, e.o, e.c);
        end
        @(negedge clock);
        reset = 1'b1;
        drive(18'd0);
        push_exp(DEF);
        #2 e = sb.pop_front();
        n_chk++;
        if (outv !== e.o || cont !== e.c) begin
            n_fail++;
            $display("FAIL reset_release: outs=%b cont=%0d, want outs=%b cont=%0d", outv, cont, e.o, e.c);
        end
    endtask

    task automatic test_load_use;
        logic [24:0] tbl [6] = '{
            {5'd5, 5'd0, 5'd5, 3'b100, LU },   // rs matches load target
            {5'd5, 5'd0, 5'd5, 3'b000, DEF},   // load moved on: no stall
            {5'd5, 5'd0, 5'd0, 3'b100, DEF},   // load targets $0
            {5'd3, 5'd7, 5'd7, 3'b100, LU },   // rt matches load target
            {5'd3, 5'd4, 5'd7, 3'b100, DEF},   // no register match
            {5'd9, 5'd9, 5'd9, 3'b000, DEF}    // match but not a load
        };
        exp_t e;
        foreach (tbl[i]) begin
            @(negedge clock);
            drive(tbl[i][24:7]);
            push_exp(tbl[i][6:0]);
            #2 e = sb.pop_front();
            n_chk++;
            if (outv !== e.o || cont !== e.c) begin
                n_fail++;
                $display("FAIL load_use[%0d]: outs=%b cont=%0d, want outs=%b cont=%0d", i, outv, cont, e.o, e.c);
            end
        end
    endtask

    task automatic test_branch;
        logic [24:0] tbl [4] = '{
            {5'd5, 5'd0, 5'd5, 3'b101, BR },   // branch beats load-use
            {5'd0, 5'd0, 5'd0, 3'b011, BR },   // branch beats MULT/DIV entry
            {5'd0, 5'd0, 5'd0, 3'b001, BR },
            {5'd0, 5'd0, 5'd0, 3'b000, DEF}
        };
        exp_t e;
        foreach (tbl[i]) begin
            @(negedge clock);
            drive(tbl[i][24:7]);
            push_exp(tbl[i][6:0]);
            #2 e = sb.pop_front();
            n_chk++;
            if (outv !== e.o || cont !== e.c) begin
                n_fail++;
                $display("FAIL branch[%0d]: outs=%b cont=%0d, want outs=%b cont=%0d", i, outv, cont, e.o, e.c);
            end
        end
    endtask

    task automatic test_multdiv_branch;
        logic [24:0] tbl [5] = '{
            {5'd0, 5'd0, 5'd0, 3'b010, MD },
            {5'd0, 5'd0, 5'd0, 3'b011, MD },   // branch ignored while busy
            {5'd5, 5'd0, 5'd5, 3'b111, MD },   // branch + load-use ignored
            {5'd5, 5'd0, 5'd5, 3'b101, RDY},   // release cycle skips hazard checks
            {5'd0, 5'd0, 5'd0, 3'b000, DEF}
        };
        exp_t e;
        foreach (tbl[i]) begin
            @(negedge clock);
            drive(tbl[i][24:7]);
            push_exp(tbl[i][6:0]);
            #2 e = sb.pop_front();
            n_chk++;
            if (outv !== e.o || cont !== e.c) begin
                n_fail++;
                $display("FAIL multdiv_branch[%0d]: outs=%b cont=%0d, want outs=%b cont=%0d", i, outv, cont, e.o, e.c);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [6:0] seq [9] = '{MD, MD, MD, RDY, MD, MD, MD, RDY, DEF};
        exp_t e;
        foreach (seq[i]) begin
            @(negedge clock);
            drive({15'd0, 1'b0, (i < 8), 1'b0});
            push_exp(seq[i]);
            #2 e = sb.pop_front();
            n_chk++;
            if (outv !== e.o || cont !== e.c) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: outs=%b cont=%0d, want outs=%b cont=%0d", i, outv, cont, e.o, e.c);
            end
        end
    endtask

    task automatic test_reset_mid_busy;
        logic [6:0] seq [5] = '{MD, MD, MD, RDY, DEF};
        exp_t e;
        // Enter OCUPADO and run down to cnt==1.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            drive({15'd0, 3'b010});
            push_exp(MD);
            #2 e = sb.pop_front();
            n_chk++;
            if (outv !== e.o || cont !== e.c) begin
                n_fail++;
                $display("FAIL busy_pre_reset[%0d]: outs=%b cont=%0d, want outs=%b cont=%0d", i, outv, cont, e.o, e.c);
            end
        end
        #1 reset = 1'b0;
        exp_cont = 0; exp_cont2 = 0;
        push_exp(DEF);
        #1 e = sb.pop_front();
        n_chk++;
        if (outv !== e.o || cont !== e.c) begin
            n_fail++;
            $display("FAIL busy_in_reset: outs=%b cont=%0d, want outs=%b cont=%0d", outv, cont, e.o, e.c);
        end
        @(negedge clock);
        reset = 1'b1;
        // A fresh MULT/DIV must run the full sequence again.
        foreach (seq[i]) begin
            if (i > 0) @(negedge clock);
            drive({15'd0, 1'b0, (i < 4), 1'b0});
            push_exp(seq[i]);
            #2 e = sb.pop_front();
            n_chk++;
            if (outv !== e.o || cont !== e.c) begin
                n_fail++;
                $display("FAIL busy_restart[%0d]: outs=%b cont=%0d, want outs=%b cont=%0d", i, outv, cont, e.o, e.c);
            end
        end
    endtask

    task automatic test_saturation;
        exp_t e;
        @(negedge clock);
        reset = 1'b0;
        exp_cont = 0; exp_cont2 = 0;
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 21; i++) begin
            if (i > 0) @(negedge clock);
            drive({5'd5, 5'd0, 5'd5, (i < 20), 2'b00});
            push_exp((i < 20) ? LU : DEF);
            #2 e = sb.pop_front();
            n_chk++;
            if (outv !== e.o || cont !== e.c || cont2 !== e.c2) begin
                n_fail++;
                $display("FAIL saturation[%0d]: outs=%b cont=%0d cont4=%0d, want outs=%b cont=%0d cont4=%0d",
                         i, outv, cont, cont2, e.o, e.c, e.c2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_back_to_back();
        test_branch();
        test_multdiv_branch();
        test_reset_mid_busy();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
